// File: rtl/stream_mux_arb.sv
// N-channel registered stream mux with valid/ready handshake.
// Channel choice is either an explicit select or round-robin arbitration.
module stream_mux_arb #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    parameter int MODE   = 0,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     sel_err
);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              sel_err_q, sel_err_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic              load_en;
    logic              chosen;
    logic [SEL_W-1:0]  ch;
    logic [DATA_W-1:0] ch_data;
    logic              ch_valid;
    logic              xfer_in;

    always_comb begin
        load_en  = !out_valid_q || out_ready;
        chosen   = 1'b0;
        ch       = '0;
        ch_data  = '0;
        ch_valid = 1'b0;
        in_ready = '0;

        if (MODE == 0) begin
            for (int i = 0; i < N_CH; i++) begin
                if (sel == SEL_W'(i)) begin
                    chosen = 1'b1;
                    ch     = SEL_W'(i);
                end
            end
        end else begin
            // Walk the search order backwards so the nearest
            // valid channel after rr_ptr wins the last write.
            for (int k = N_CH; k >= 1; k--) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (in_valid[i] &&
                        (i == (int'(rr_ptr_q) + k) % N_CH)) begin
                        chosen = 1'b1;
                        ch     = SEL_W'(i);
                    end
                end
            end
        end

        for (int i = 0; i < N_CH; i++) begin
            if (chosen && (ch == SEL_W'(i))) begin
                in_ready[i] = load_en;
                ch_data     = in_data[i*DATA_W +: DATA_W];
                ch_valid    = in_valid[i];
            end
        end

        xfer_in = load_en && ch_valid;

        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = (MODE == 0) && !chosen;

        if (xfer_in) begin
            out_data_d  = ch_data;
            out_ch_d    = ch;
            out_valid_d = 1'b1;
            if (MODE != 0) rr_ptr_d = ch;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: select mode (8 and 6 channels)
// and round-robin mode, each with hand-computed expectations.
module tb_stream_mux_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // u0: MODE 0, 8 channels
    logic [63:0] a_data;
    logic [7:0]  a_valid, a_ready;
    logic [2:0]  a_sel, a_ch;
    logic [7:0]  a_odata;
    logic        a_ovalid, a_oready, a_err;

    // u1: MODE 0, 6 channels
    logic [47:0] b_data;
    logic [5:0]  b_valid, b_ready;
    logic [2:0]  b_sel, b_ch;
    logic [7:0]  b_odata;
    logic        b_ovalid, b_oready, b_err;

    // u2: MODE 1, 8 channels
    logic [63:0] c_data;
    logic [7:0]  c_valid, c_ready;
    logic [2:0]  c_sel, c_ch;
    logic [7:0]  c_odata;
    logic        c_ovalid, c_oready, c_err;

    stream_mux_arb #(.N_CH(8), .DATA_W(8), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .sel(a_sel), .out_data(a_odata),
        .out_valid(a_ovalid), .out_ready(a_oready), .out_ch(a_ch),
        .sel_err(a_err));

    stream_mux_arb #(.N_CH(6), .DATA_W(8), .MODE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .sel(b_sel), .out_data(b_odata),
        .out_valid(b_ovalid), .out_ready(b_oready), .out_ch(b_ch),
        .sel_err(b_err));

    stream_mux_arb #(.N_CH(8), .DATA_W(8), .MODE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
        .in_ready(c_ready), .sel(c_sel), .out_data(c_odata),
        .out_valid(c_ovalid), .out_ready(c_oready), .out_ch(c_ch),
        .sel_err(c_err));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_data = '0; a_valid = '0; a_sel = '0; a_oready = 1'b0;
        b_data = '0; b_valid = '0; b_sel = '0; b_oready = 1'b0;
        c_data = '0; c_valid = '0; c_sel = '0; c_oready = 1'b0;

        #12;
        chk("rst_a_valid", 32'(a_ovalid), 0);
        chk("rst_a_data", 32'(a_odata), 0);
        chk("rst_a_ch", 32'(a_ch), 0);
        chk("rst_a_err", 32'(a_err), 0);
        chk("rst_c_valid", 32'(c_ovalid), 0);
        rst_n = 1'b1;
        edge1();

        // select mode: ch3 -> A5
        a_sel = 3'd3; a_valid = 8'h08; a_oready = 1'b1;
        a_data[3*8 +: 8] = 8'hA5;
        #1;
        chk("sel3_ready", 32'(a_ready), 32'h08);
        edge1();
        chk("sel3_data", 32'(a_odata), 32'hA5);
        chk("sel3_ch", 32'(a_ch), 3);
        chk("sel3_valid", 32'(a_ovalid), 1);
        chk("sel3_err", 32'(a_err), 0);

        // stall for 4 clocks with the next word waiting
        a_oready = 1'b0;
        a_data[3*8 +: 8] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_ready", 32'(a_ready), 0);
            chk("stall_data", 32'(a_odata), 32'hA5);
            chk("stall_valid", 32'(a_ovalid), 1);
            edge1();
        end
        a_oready = 1'b1;
        #1;
        chk("unstall_ready", 32'(a_ready), 32'h08);
        edge1();
        chk("nobubble_data", 32'(a_odata), 32'h5A);
        chk("nobubble_valid", 32'(a_ovalid), 1);

        // select points at an idle channel: ready offered, nothing loads
        a_sel = 3'd1;
        #1;
        chk("idle_sel_ready", 32'(a_ready), 32'h02);
        edge1();
        chk("idle_sel_valid", 32'(a_ovalid), 0);
        chk("idle_sel_hold", 32'(a_odata), 32'h5A);
        a_valid = '0;

        // 6 channels: out-of-range select
        b_data = 48'h665544332211;
        b_valid = 6'h3F; b_oready = 1'b1;
        b_sel = 3'd5;
        #1;
        chk("n6_sel5_ready", 32'(b_ready), 32'h20);
        b_sel = 3'd7;
        #1;
        chk("n6_sel7_ready", 32'(b_ready), 0);
        edge1();
        chk("n6_err_hi", 32'(b_err), 1);
        chk("n6_noload", 32'(b_ovalid), 0);
        b_sel = 3'd2;
        edge1();
        chk("n6_err_lo", 32'(b_err), 0);
        chk("n6_ch2_valid", 32'(b_ovalid), 1);
        chk("n6_ch2_ch", 32'(b_ch), 2);
        chk("n6_ch2_data", 32'(b_odata), 32'h33);
        b_valid = '0;

        // round robin: all channels valid
        for (int i = 0; i < 8; i++) c_data[i*8 +: 8] = 8'(8'h10 + i);
        c_valid = 8'hFF; c_oready = 1'b1;
        c_sel = 3'd6;
        #1;
        chk("rr_first_ready", 32'(c_ready), 32'h01);
        for (int k = 0; k < 9; k++) begin
            edge1();
            chk("rr_all_ch", 32'(c_ch), 32'(k % 8));
            chk("rr_all_data", 32'(c_odata), 32'(8'h10 + (k % 8)));
            chk("rr_all_valid", 32'(c_ovalid), 1);
            chk("rr_all_err", 32'(c_err), 0);
        end

        // only ch2 and ch5 valid, pointer now at 0
        c_valid = 8'h24;
        edge1();
        chk("rr25_g0", 32'(c_ch), 2);
        edge1();
        chk("rr25_g1", 32'(c_ch), 5);
        edge1();
        chk("rr25_wrap", 32'(c_ch), 2);
        edge1();
        chk("rr25_g3", 32'(c_ch), 5);
        c_valid = '0;
        #1;
        chk("rr_idle_ready", 32'(c_ready), 0);
        edge1();
        chk("rr_drain_valid", 32'(c_ovalid), 0);
        chk("rr_drain_ch", 32'(c_ch), 5);
        edge1();
        chk("rr_idle_valid", 32'(c_ovalid), 0);

        // reset in the middle of a cycle with a word pending
        a_sel = 3'd3; a_valid = 8'h08; a_oready = 1'b0;
        edge1();
        chk("pre_rst_valid", 32'(a_ovalid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(a_ovalid), 0);
        chk("mid_rst_data", 32'(a_odata), 0);
        chk("mid_rst_ch", 32'(a_ch), 0);
        a_valid = '0;
        #1;
        rst_n = 1'b1;
        c_valid = 8'hFF;
        edge1();
        chk("rst_rr_ptr", 32'(c_ch), 0);
        chk("rst_rr_valid", 32'(c_ovalid), 1);
        c_valid = '0;
        edge1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
